// File: rtl/full_adder_pkg.sv
// rtl/full_adder_pkg.sv - shared constants and width check for the full adder
package full_adder_pkg;

    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 64;

    function automatic bit width_ok(input int w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// rtl/full_adder_cell.sv - one-bit combinational full adder cell
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);

    logic p;

    assign p  = a ^ b;
    assign s  = p ^ cin;
    assign co = (a & b) | (cin & p);

endmodule

// File: rtl/full_adder.sv
// rtl/full_adder.sv - ripple-carry adder with optional registered output stage
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter bit REG_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    input  logic             in_valid,
    output logic             out_valid
);

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("full_adder: WIDTH=%0d outside %0d..%0d", WIDTH, WIDTH_MIN, WIDTH_MAX);
    end

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;

    assign carry[0] = cin;

    // Ripple chain, LSB first; carry[i+1] feeds the next cell up.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_cell u_cell (
            .a   (a[i]),
            .b   (b[i]),
            .cin (carry[i]),
            .s   (sum_d[i]),
            .co  (carry[i+1])
        );
    end

    assign cout_d = carry[WIDTH];

    if (REG_OUT) begin : g_reg
        logic [WIDTH-1:0] sum_q;
        logic             cout_q;
        logic             valid_q;

        // Data registers only load on a valid beat, so idle cycles hold the last result.
        always_ff @(posedge clk) begin
            if (rst) begin
                sum_q   <= '0;
                cout_q  <= 1'b0;
                valid_q <= 1'b0;
            end else begin
                valid_q <= in_valid;
                if (in_valid) begin
                    sum_q  <= sum_d;
                    cout_q <= cout_d;
                end
            end
        end

        assign sum       = sum_q;
        assign cout      = cout_q;
        assign out_valid = valid_q;
    end else begin : g_comb
        logic unused_clk_rst;

        assign unused_clk_rst = &{1'b0, clk, rst};
        assign sum            = sum_d;
        assign cout           = cout_d;
        assign out_valid      = in_valid;
    end

endmodule

// File: tb/tb_full_adder.sv
// tb/tb_full_adder.sv - directed self-checking bench for full_adder
module tb_full_adder;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rst_c = 1'b0;

    logic       a1, b1, c1, v1;
    logic       s1, co1, ov1;
    logic [3:0] a4, b4, s4;
    logic       c4, v4, co4, ov4;
    logic [7:0] a8, b8, s8;
    logic       c8, v8, co8, ov8;
    logic       ac, bc, cc, vc;
    logic       sc, coc, ovc;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0] exp_tt [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    always #5 clk = ~clk;

    full_adder #(.WIDTH(1), .REG_OUT(1'b1)) u_w1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(c1),
        .sum(s1), .cout(co1), .in_valid(v1), .out_valid(ov1)
    );

    full_adder #(.WIDTH(4), .REG_OUT(1'b1)) u_w4 (
        .clk(clk), .rst(rst), .a(a4), .b(b4), .cin(c4),
        .sum(s4), .cout(co4), .in_valid(v4), .out_valid(ov4)
    );

    full_adder #(.WIDTH(8), .REG_OUT(1'b1)) u_w8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .cin(c8),
        .sum(s8), .cout(co8), .in_valid(v8), .out_valid(ov8)
    );

    full_adder #(.WIDTH(1), .REG_OUT(1'b0)) u_c1 (
        .clk(clk), .rst(rst_c), .a(ac), .b(bc), .cin(cc),
        .sum(sc), .cout(coc), .in_valid(vc), .out_valid(ovc)
    );

    task automatic test_reset();
        rst = 1'b1;
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; v1 = 1'b1;
        a4 = 4'h7; b4 = 4'h9; c4 = 1'b1; v4 = 1'b1;
        a8 = 8'hA5; b8 = 8'h77; c8 = 1'b1; v8 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({ov1, co1, s1} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_w1: got ov/cout/sum=%b expected 000", {ov1, co1, s1});
        end
        n_checks++;
        if ({ov4, co4, s4} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_w4: got ov/cout/sum=%b expected 000000", {ov4, co4, s4});
        end
        n_checks++;
        if ({ov8, co8, s8} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_w8: got ov/cout/sum=%h expected 000", {ov8, co8, s8});
        end
        rst = 1'b0;
        v1 = 1'b0; v4 = 1'b0; v8 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_truth_table();
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            if (i > 0) begin
                n_checks++;
                if ({ov1, co1, s1} !== {1'b1, exp_tt[i-1]}) begin
                    n_fail++;
                    $display("FAIL truth_table[%0d]: got ov/cout/sum=%b expected %b",
                             i - 1, {ov1, co1, s1}, {1'b1, exp_tt[i-1]});
                end
            end
            if (i < 8) begin
                {a1, b1, c1} = 3'(i);
                v1 = 1'b1;
            end
        end
        v1 = 1'b0;
    endtask

    task automatic test_boundary();
        @(negedge clk);
        a4 = 4'hF; b4 = 4'hF; c4 = 1'b1; v4 = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({ov4, co4, s4} !== 6'b1_1_1111) begin
            n_fail++;
            $display("FAIL boundary_all_ones: got ov/cout/sum=%b expected 111111", {ov4, co4, s4});
        end
        a4 = 4'h8; b4 = 4'h8; c4 = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({ov4, co4, s4} !== 6'b1_1_0000) begin
            n_fail++;
            $display("FAIL boundary_msb_carry: got ov/cout/sum=%b expected 110000", {ov4, co4, s4});
        end
        v4 = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({ov4, co4, s4} !== 6'b0_1_0000) begin
            n_fail++;
            $display("FAIL boundary_hold: got ov/cout/sum=%b expected 010000", {ov4, co4, s4});
        end
    endtask

    task automatic test_valid_gap();
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b0; c1 = 1'b0; v1 = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({ov1, co1, s1} !== 3'b101) begin
            n_fail++;
            $display("FAIL gap_first: got ov/cout/sum=%b expected 101", {ov1, co1, s1});
        end
        a1 = 1'bx; b1 = 1'bz; c1 = 1'bx; v1 = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({ov1, co1, s1} !== 3'b001) begin
            n_fail++;
            $display("FAIL gap_hold_x: got ov/cout/sum=%b expected 001", {ov1, co1, s1});
        end
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; v1 = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({ov1, co1, s1} !== 3'b111) begin
            n_fail++;
            $display("FAIL gap_resume: got ov/cout/sum=%b expected 111", {ov1, co1, s1});
        end
    endtask

    task automatic test_reset_mid_stream();
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b0; v1 = 1'b1;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_checks++;
            if ({ov1, co1, s1} !== 3'b000) begin
                n_fail++;
                $display("FAIL mid_reset[%0d]: got ov/cout/sum=%b expected 000", k, {ov1, co1, s1});
            end
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({ov1, co1, s1} !== 3'b110) begin
            n_fail++;
            $display("FAIL after_reset: got ov/cout/sum=%b expected 110", {ov1, co1, s1});
        end
        v1 = 1'b0;
    endtask

    task automatic test_back_to_back_random();
        logic [8:0] exp_prev;
        for (int i = 0; i <= 1000; i++) begin
            @(negedge clk);
            if (i > 0) begin
                n_checks++;
                if ({ov8, co8, s8} !== {1'b1, exp_prev}) begin
                    n_fail++;
                    $display("FAIL random[%0d]: got ov/cout/sum=%h expected %h",
                             i - 1, {ov8, co8, s8}, {1'b1, exp_prev});
                end
            end
            if (i < 1000) begin
                a8 = 8'($urandom);
                b8 = 8'($urandom);
                c8 = 1'($urandom);
                v8 = 1'b1;
                exp_prev = 9'(a8) + 9'(b8) + 9'(c8);
            end
        end
        v8 = 1'b0;
    endtask

    task automatic test_comb();
        for (int i = 0; i < 8; i++) begin
            {ac, bc, cc} = 3'(i);
            vc    = (i % 2) == 0;
            rst_c = (i % 4) >= 2;
            #1;
            n_checks++;
            if ({ovc, coc, sc} !== {vc, exp_tt[i]}) begin
                n_fail++;
                $display("FAIL comb[%0d]: got ov/cout/sum=%b expected %b", i, {ovc, coc, sc}, {vc, exp_tt[i]});
            end
            #4;
        end
        rst_c = 1'b0;
    endtask

    initial begin
        {a1, b1, c1, v1} = '0;
        {a4, b4, c4, v4} = '0;
        {a8, b8, c8, v8} = '0;
        {ac, bc, cc, vc} = '0;
        test_reset();
        test_truth_table();
        test_boundary();
        test_valid_gap();
        test_reset_mid_stream();
        test_back_to_back_random();
        test_comb();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/full_adder.md
FULL_ADDER -- requirements
Module: full_adder

Interface
REQ-001 Parameter: WIDTH, default 1, operand width in bits; legal range 1..64.
REQ-002 Parameter: REG_OUT, default 1, 1 = registered outputs, 0 = combinational outputs.
REQ-003 Port: clk  input  1  single clock, rising edge active.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: a  input  WIDTH  addend A (first data port).
REQ-006 Port: b  input  WIDTH  addend B (second data port).
REQ-007 Port: cin  input  1  carry in (third data port).
REQ-008 Port: in_valid  input  1  qualifies a/b/cin this cycle.
REQ-009 Port: sum  output  WIDTH  sum bits.
REQ-010 Port: cout  output  1  carry out of MSB.
REQ-011 Port: out_valid  output  1  qualifies sum/cout.
REQ-012 Data-port order after clk/rst SHALL be a, b, cin, sum, cout, then in_valid, out_valid.

Function
REQ-013 Per bit i: s_i = a_i XOR b_i XOR c_i; c_(i+1) = (a_i AND b_i) OR (c_i AND (a_i XOR b_i)); c_0 = cin.
REQ-014 {cout, sum} SHALL equal a + b + cin exactly (WIDTH+1-bit result, no truncation, no saturation).
REQ-015 Carry chain SHALL be ripple order LSB to MSB; no lookahead required.
REQ-016 REG_OUT=1: sum/cout/out_valid SHALL update on the rising clk edge after inputs are sampled (latency 1 cycle).
REQ-017 REG_OUT=1: when in_valid=0, sum and cout SHALL hold their previous values; out_valid SHALL be 0 next cycle.
REQ-018 REG_OUT=1: back-to-back in_valid=1 cycles SHALL produce one result per cycle, no bubbles, no backpressure.
REQ-019 REG_OUT=0: sum/cout SHALL be combinational from a/b/cin (latency 0); out_valid = in_valid.
REQ-020 Boundary: all-ones a and b with cin=1 SHALL give sum = all-ones, cout = 1.
REQ-021 X/Z on inputs with in_valid=0 SHALL NOT change registered outputs.

Reset
REQ-022 REG_OUT=1: rst=1 at a rising edge SHALL force sum=0, cout=0, out_valid=0, overriding in_valid.
REQ-023 Reset asserted mid-stream SHALL discard the in-flight result; first valid output after release appears one cycle after the first in_valid=1 sampled with rst=0.
REQ-024 REG_OUT=0: rst has no effect on outputs.

Structure
REQ-025 One sub-module full_adder_cell: 1-bit combinational cell (a, b, cin -> s, co) per REQ-013, replicated WIDTH times via generate.
REQ-026 No shared package required; WIDTH bound check SHALL be an elaboration-time assertion inside full_adder.
REQ-027 Output register stage SHALL be the only sequential logic; no latches.

Verification
REQ-028 WIDTH=1, REG_OUT=1: apply all 8 {a,b,cin} from 000 to 111, one per cycle, in_valid=1 -> {cout,sum} = 00,01,01,10,01,10,10,11 one cycle later each, out_valid=1.
REQ-029 WIDTH=4: a=4'hF, b=4'hF, cin=1 -> sum=4'hF, cout=1; a=4'h8, b=4'h8, cin=0 -> sum=4'h0, cout=1.
REQ-030 in_valid toggles 1,0,1 with a=1,b=0,cin=0 then a=1,b=1,cin=1 -> out_valid 1,0,1; sum holds 1 during the gap cycle, then sum=1, cout=1.
REQ-031 rst=1 for 2 cycles mid-stream (a=1,b=1,cin=0 presented) -> sum=0, cout=0, out_valid=0 during reset; first result after release = 10.
REQ-032 WIDTH=8, 1000 random vectors -> {cout,sum} matches a+b+cin every cycle, latency exactly 1.
REQ-033 REG_OUT=0, WIDTH=1: exhaustive 8 vectors, 5 time units apart -> outputs match truth table within the same time step.
